// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the word-addressed PC, registers the fetched
// word into IF/ID, and handles stall, flush, redirect and the HALT instruction.
module fetch_stage #(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instruction,
  output logic [31:0] address,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus1,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus1;
    logic        valid;
  } ifid_t;

  state_t         state;
  ifid_t          ifid;
  logic [AW-1:0]  pc;
  logic [AW-1:0]  pc_next;
  logic [31:0]    pc_next32;
  logic [AW-1:0]  tgt;
  logic           unused_tgt_hi;

  // AW-bit add wraps the PC modulo MEM_DEPTH for free
  assign pc_next       = pc + 1'b1;
  assign pc_next32     = {{(32-AW){1'b0}}, pc_next};
  assign tgt           = redirect_target[AW-1:0];
  assign unused_tgt_hi = ^redirect_target[31:AW];

  assign address        = {{(32-AW){1'b0}}, pc};
  assign if_id_instr    = ifid.instr;
  assign if_id_pc_plus1 = ifid.pc_plus1;
  assign if_id_valid    = ifid.valid;
  assign halted         = (state == HALTED);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC[AW-1:0];
      ifid        <= '0;
      state       <= RUN;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc    <= tgt;
      ifid  <= '0;
      state <= RUN;
    end else if (state == HALTED) begin
      if (flush || !stall) ifid <= '0;
    end else if (stall) begin
      if (flush) ifid <= '0;
    end else if (flush) begin
      // fetched word is dropped but the PC still advances past it
      ifid <= '0;
      pc   <= pc_next;
    end else if (instruction == HALT_WORD) begin
      ifid        <= '{instr: HALT_WORD, pc_plus1: pc_next32, valid: 1'b1};
      state       <= HALTED;
      fetch_count <= fetch_count + 32'd1;
    end else begin
      ifid        <= '{instr: instruction, pc_plus1: pc_next32, valid: 1'b1};
      pc          <= pc_next;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for the main flow plus
// hand-written HALT, wrap and mid-run reset sequences.
module tb_fetch_stage;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instruction;
  logic [31:0] address, if_id_instr, if_id_pc_plus1, fetch_count;
  logic        if_id_valid, halted;

  logic [31:0] mem [1024];

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        s, f, rv;
    logic [31:0] tgt;
    logic [31:0] ea, ei, ep;
    logic        ev, eh;
    logic [31:0] ec;
  } vec_t;

  vec_t vq[$];

  fetch_stage #(.MEM_DEPTH(1024), .RESET_PC(32'd0), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instruction(instruction), .address(address), .if_id_instr(if_id_instr),
    .if_id_pc_plus1(if_id_pc_plus1), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign instruction = mem[address[9:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] ea, input logic [31:0] ei,
                            input logic [31:0] ep, input logic ev, input logic eh,
                            input logic [31:0] ec);
    chk({tag, ".address"}, address, ea);
    chk({tag, ".if_id_instr"}, if_id_instr, ei);
    chk({tag, ".if_id_pc_plus1"}, if_id_pc_plus1, ep);
    chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, ev});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
    chk({tag, ".fetch_count"}, fetch_count, ec);
  endtask

  // drive inputs, clock one edge, then sample 1 time unit later
  task automatic step(input logic s, input logic f, input logic rv, input logic [31:0] tgt);
    stall = s; flush = f; redirect_valid = rv; redirect_target = tgt;
    @(posedge clk); #1;
  endtask

  task automatic add(input logic s, input logic f, input logic rv, input logic [31:0] tgt,
                     input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                     input logic ev, input logic eh, input logic [31:0] ec);
    vec_t v;
    v.s = s; v.f = f; v.rv = rv; v.tgt = tgt;
    v.ea = ea; v.ei = ei; v.ep = ep; v.ev = ev; v.eh = eh; v.ec = ec;
    vq.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = (i < 8) ? 32'(i + 1) * 32'h11 : (32'hA000_0000 | 32'(i));

    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    @(posedge clk); @(posedge clk); #1;
    expect_out("reset", 32'd0, 32'd0, 32'd0, N, N, 32'd0);
    rst = 1'b1;

    //   stall flush rv  target        addr     instr          pc+1    vld hlt cnt
    add(N, N, N, 32'd0,     32'd1,   32'h11,        32'd1,  Y, N, 32'd1);
    add(N, N, N, 32'd0,     32'd2,   32'h22,        32'd2,  Y, N, 32'd2);
    add(Y, N, N, 32'd0,     32'd2,   32'h22,        32'd2,  Y, N, 32'd2);
    add(Y, N, N, 32'd0,     32'd2,   32'h22,        32'd2,  Y, N, 32'd2);
    add(Y, N, N, 32'd0,     32'd2,   32'h22,        32'd2,  Y, N, 32'd2);
    add(N, N, N, 32'd0,     32'd3,   32'h33,        32'd3,  Y, N, 32'd3);
    add(N, N, N, 32'd0,     32'd4,   32'h44,        32'd4,  Y, N, 32'd4);
    add(N, N, N, 32'd0,     32'd5,   32'h55,        32'd5,  Y, N, 32'd5);
    add(Y, N, Y, 32'h410,   32'h10,  32'd0,         32'd0,  N, N, 32'd5);
    add(N, N, N, 32'd0,     32'h11,  32'hA000_0010, 32'h11, Y, N, 32'd6);
    add(N, N, Y, 32'd7,     32'd7,   32'd0,         32'd0,  N, N, 32'd6);
    add(N, Y, N, 32'd0,     32'd8,   32'd0,         32'd0,  N, N, 32'd6);
    add(N, N, N, 32'd0,     32'd9,   32'hA000_0008, 32'd9,  Y, N, 32'd7);
    add(Y, Y, N, 32'd0,     32'd9,   32'd0,         32'd0,  N, N, 32'd7);
    add(N, N, N, 32'd0,     32'd10,  32'hA000_0009, 32'd10, Y, N, 32'd8);

    foreach (vq[i]) begin
      step(vq[i].s, vq[i].f, vq[i].rv, vq[i].tgt);
      expect_out($sformatf("vec%0d", i), vq[i].ea, vq[i].ei, vq[i].ep,
                 vq[i].ev, vq[i].eh, vq[i].ec);
    end

    // HALT in word 3
    mem[3] = 32'hFFFF_FFFF;
    step(N, N, Y, 32'd0);
    expect_out("h_redir", 32'd0, 32'd0, 32'd0, N, N, 32'd8);
    step(N, N, N, 32'd0);
    expect_out("h_w0", 32'd1, 32'h11, 32'd1, Y, N, 32'd9);
    step(N, N, N, 32'd0);
    expect_out("h_w1", 32'd2, 32'h22, 32'd2, Y, N, 32'd10);
    step(N, N, N, 32'd0);
    expect_out("h_w2", 32'd3, 32'h33, 32'd3, Y, N, 32'd11);
    step(N, N, N, 32'd0);
    expect_out("h_halt", 32'd3, 32'hFFFF_FFFF, 32'd4, Y, Y, 32'd12);
    for (int i = 0; i < 10; i++) begin
      step(N, N, N, 32'd0);
      expect_out($sformatf("h_idle%0d", i), 32'd3, 32'd0, 32'd0, N, Y, 32'd12);
    end
    step(N, N, Y, 32'd0);
    expect_out("h_exit", 32'd0, 32'd0, 32'd0, N, N, 32'd12);
    step(N, N, N, 32'd0);
    expect_out("h_resume", 32'd1, 32'h11, 32'd1, Y, N, 32'd13);

    // wrap from the last word back to 0
    step(N, N, Y, 32'd1023);
    expect_out("w_redir", 32'd1023, 32'd0, 32'd0, N, N, 32'd13);
    step(N, N, N, 32'd0);
    expect_out("w_last", 32'd0, 32'hA000_03FF, 32'd0, Y, N, 32'd14);
    step(N, N, N, 32'd0);
    expect_out("w_zero", 32'd1, 32'h11, 32'd1, Y, N, 32'd15);

    // reset mid-run beats a simultaneous redirect
    rst = 1'b0;
    step(N, N, Y, 32'd40);
    expect_out("mid_rst", 32'd0, 32'd0, 32'd0, N, N, 32'd0);
    rst = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
